// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Staggered header-switch sequencer: ramps segments on one at a time, waits for
// power-good, de-isolates; on power-down isolates first, then ramps off in reverse.
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
  parameter int NSEG    = 8,
  parameter int STAGGER = 4,
  parameter int ISO_DLY = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PWR_REQ,
  input  logic            PG_ACK,
  output logic [NSEG-1:0] SW_EN,
  output logic            ISO,
  output logic            PWR_GOOD,
  output logic            BUSY,
  output logic            ERR
);

  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IW = (ISO_DLY > 1) ? $clog2(ISO_DLY) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NSEG-1:0] ALL_ON = '1;

  typedef enum logic [2:0] {
    S_OFF,
    S_RAMP_UP,
    S_WAIT_ACK,
    S_ON,
    S_ISO_HOLD,
    S_RAMP_DN,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [NSEG-1:0] sw_d, sw_up, sw_dn;
  logic [SW-1:0]   stg_q, stg_d;
  logic [IW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            stg_hit;
  state_t          up_state, dn_state;
  logic            iso_d, pg_d, busy_d, err_d;

  always_comb begin
    state_d = state_q;
    sw_d    = SW_EN;
    stg_d   = '0;
    hold_d  = '0;
    tmo_d   = '0;

    // Thermometer step: shift in a one at the bottom, or drop the top one.
    sw_up    = (SW_EN << 1) | NSEG'(1);
    sw_dn    = SW_EN >> 1;
    stg_hit  = (stg_q == SW'(STAGGER - 1));
    up_state = (sw_up == ALL_ON) ? S_WAIT_ACK : S_RAMP_UP;
    dn_state = (sw_dn == '0) ? S_OFF : S_RAMP_DN;

    case (state_q)
      S_OFF: begin
        if (PWR_REQ) begin
          sw_d    = sw_up;
          state_d = up_state;
        end
      end
      S_RAMP_UP: begin
        if (!PWR_REQ) begin
          sw_d    = sw_dn;
          state_d = dn_state;
        end else if (stg_hit) begin
          sw_d    = sw_up;
          state_d = up_state;
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (!PWR_REQ) begin
          sw_d    = sw_dn;
          state_d = dn_state;
        end else if (PG_ACK) begin
          state_d = S_ON;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          sw_d    = '0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ON: begin
        if (!PWR_REQ) state_d = S_ISO_HOLD;
      end
      S_ISO_HOLD: begin
        if (hold_q == IW'(ISO_DLY - 1)) begin
          sw_d    = sw_dn;
          state_d = dn_state;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RAMP_DN: begin
        if (PWR_REQ) begin
          sw_d    = sw_up;
          state_d = up_state;
        end else if (stg_hit) begin
          sw_d    = sw_dn;
          state_d = dn_state;
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      S_FAULT: begin
        if (!PWR_REQ) state_d = S_OFF;
      end
      default: begin
        sw_d    = '0;
        state_d = S_OFF;
      end
    endcase

    // Flags are decoded from the next state so they land on the same edge as it.
    iso_d  = (state_d != S_ON);
    pg_d   = (state_d == S_ON);
    busy_d = !(state_d == S_OFF || state_d == S_ON || state_d == S_FAULT);
    err_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_OFF;
      SW_EN    <= '0;
      stg_q    <= '0;
      hold_q   <= '0;
      tmo_q    <= '0;
      ISO      <= 1'b1;
      PWR_GOOD <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      SW_EN    <= sw_d;
      stg_q    <= stg_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      ISO      <= iso_d;
      PWR_GOOD <= pg_d;
      BUSY     <= busy_d;
      ERR      <= err_d;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Scoreboard bench for the power-switch sequencer (NSEG=4, STAGGER=3, ISO_DLY=2, TIMEOUT=16).
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PWR_REQ = 1'b0;
  logic       PG_ACK = 1'b0;
  logic [3:0] SW_EN;
  logic       ISO, PWR_GOOD, BUSY, ERR;

  gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
    .NSEG(4),
    .STAGGER(3),
    .ISO_DLY(2),
    .TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PWR_REQ(PWR_REQ),
    .PG_ACK(PG_ACK),
    .SW_EN(SW_EN),
    .ISO(ISO),
    .PWR_GOOD(PWR_GOOD),
    .BUSY(BUSY),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] exp;
    string      name;
    int         edge_n;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic logic [7:0] ex(input logic [3:0] sw, input logic iso, input logic pg,
                                    input logic busy, input logic err);
    return {sw, iso, pg, busy, err};
  endfunction

  // Drive inputs for the coming edge and queue what the outputs must be after it.
  task automatic cyc(input logic rst, input logic req, input logic ack,
                     input logic [7:0] exp, input string name, input int e);
    sb_t ent;
    RST     = rst;
    PWR_REQ = req;
    PG_ACK  = ack;
    ent.exp    = exp;
    ent.name   = name;
    ent.edge_n = e;
    sb.push_back(ent);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, ex(4'b0000, 1, 0, 0, 0), name, i);
  endtask

  initial begin
    sb_t        ent;
    logic [7:0] act;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        act = {SW_EN, ISO, PWR_GOOD, BUSY, ERR};
        n_checks++;
        if (act !== ent.exp) begin
          n_fail++;
          $display("FAIL %s edge %0d: got sw=%b iso=%b pg=%b busy=%b err=%b, expected sw=%b iso=%b pg=%b busy=%b err=%b",
                   ent.name, ent.edge_n, act[7:4], act[3], act[2], act[1], act[0],
                   ent.exp[7:4], ent.exp[3], ent.exp[2], ent.exp[1], ent.exp[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] sw;
    logic       req, ack, on, flt;

    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b1, ex(4'b0000, 1, 0, 0, 0), "reset", i);
    idle(2, "off_idle");

    // Full power-up then power-down; PG_ACK dip in ON and a PWR_REQ blip in ISO_HOLD are ignored.
    for (int e = 0; e <= 33; e++) begin
      req = (e < 20) || (e == 21);
      ack = (e >= 12 && e < 15) || (e >= 17);
      sw  = (e < 3)  ? 4'b0001 : (e < 6)  ? 4'b0011 : (e < 9)  ? 4'b0111 :
            (e < 22) ? 4'b1111 : (e < 25) ? 4'b0111 : (e < 28) ? 4'b0011 :
            (e < 31) ? 4'b0001 : 4'b0000;
      on  = (e >= 12 && e < 20);
      cyc(1'b0, req, ack, ex(sw, !on, on, !on && (e < 31), 0), "pwr_up_dn", e);
    end
    idle(2, "off_idle");

    // Reversal in RAMP_UP, ramp finishes down to OFF.
    for (int e = 0; e <= 9; e++) begin
      sw = (e < 3) ? 4'b0001 : (e < 4) ? 4'b0011 : (e < 7) ? 4'b0001 : 4'b0000;
      cyc(1'b0, e < 4, 1'b0, ex(sw, 1, 0, e < 7, 0), "reverse_dn", e);
    end
    idle(1, "off_idle");

    // Reversal down then back up, then drop request from WAIT_ACK.
    for (int e = 0; e <= 23; e++) begin
      req = (e < 4) || (e >= 5 && e < 12);
      sw  = (e < 3)  ? 4'b0001 : (e < 4)  ? 4'b0011 : (e < 5)  ? 4'b0001 :
            (e < 8)  ? 4'b0011 : (e < 11) ? 4'b0111 : (e < 12) ? 4'b1111 :
            (e < 15) ? 4'b0111 : (e < 18) ? 4'b0011 : (e < 21) ? 4'b0001 : 4'b0000;
      cyc(1'b0, req, 1'b0, ex(sw, 1, 0, e < 21, 0), "reverse_up", e);
    end
    idle(1, "off_idle");

    // Power-good timeout to FAULT, then release.
    for (int e = 0; e <= 32; e++) begin
      sw  = (e < 3) ? 4'b0001 : (e < 6) ? 4'b0011 : (e < 9) ? 4'b0111 :
            (e < 25) ? 4'b1111 : 4'b0000;
      flt = (e >= 25 && e < 30);
      cyc(1'b0, e < 30, 1'b0, ex(sw, 1, 0, e < 25, flt), "timeout", e);
    end
    idle(1, "off_idle");

    // Synchronous reset mid-ramp, then restart with request still high.
    for (int e = 0; e <= 9; e++) begin
      sw = (e < 3) ? 4'b0001 : (e < 5) ? 4'b0011 : (e == 5) ? 4'b0000 :
           (e < 9) ? 4'b0001 : 4'b0011;
      cyc(e == 5, 1'b1, 1'b0, ex(sw, 1, 0, e != 5, 0), "reset_mid", e);
    end
    cyc(1'b1, 1'b0, 1'b0, ex(4'b0000, 1, 0, 0, 0), "reset_mid", 10);
    idle(1, "off_idle");

    // PG_ACK and request drop on the same WAIT_ACK edge: ramp-down wins.
    for (int e = 0; e <= 21; e++) begin
      sw = (e < 3)  ? 4'b0001 : (e < 6)  ? 4'b0011 : (e < 9)  ? 4'b0111 :
           (e < 11) ? 4'b1111 : (e < 14) ? 4'b0111 : (e < 17) ? 4'b0011 :
           (e < 20) ? 4'b0001 : 4'b0000;
      cyc(1'b0, e < 11, e == 11, ex(sw, 1, 0, e < 20, 0), "simultaneous", e);
    end
    idle(2, "off_idle");

    @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
